// File: rtl/alu_pkg.sv
// Shared constants for the ALU-64 datapath: default widths and the
// serial subtractor FSM state encoding.
package alu_pkg;
    localparam int WIDTH_D  = 64;
    localparam int SLICE_D  = 8;
    localparam int NSLICE_D = WIDTH_D / SLICE_D;
    localparam int IDXW_D   = $clog2(NSLICE_D);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/rcs8.sv
// Combinational ripple-borrow subtractor slice: z = x - y - b_in,
// built from a chain of full-subtractor cells.
module rcs8
    import alu_pkg::*;
#(
    parameter int W = SLICE_D
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         b_in,
    output logic [W-1:0] z,
    output logic         b_out
);
    logic [W:0] w_b;

    always_comb begin
        w_b    = '0;
        z      = '0;
        w_b[0] = b_in;
        for (int i = 0; i < W; i++) begin
            z[i]     = x[i] ^ y[i] ^ w_b[i];
            w_b[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b[i]);
        end
        b_out = w_b[W];
    end
endmodule

// File: rtl/serial_sub64.sv
// Multi-cycle subtractor: one SLICE-bit ripple-borrow slice per clock,
// LSB first, with a start/busy/done handshake.
module serial_sub64
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int SLICE = SLICE_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic [SLICE-1:0] w_x;
    logic [SLICE-1:0] w_y;
    logic [SLICE-1:0] w_z;
    logic             w_bo;
    logic [WIDTH-1:0] w_next_diff;

    always_comb begin
        w_x         = r_a[int'(r_idx)*SLICE +: SLICE];
        w_y         = r_b[int'(r_idx)*SLICE +: SLICE];
        w_next_diff = r_diff;
        w_next_diff[int'(r_idx)*SLICE +: SLICE] = w_z;
    end

    rcs8 #(.W(SLICE)) u_slice (
        .x     (w_x),
        .y     (w_y),
        .b_in  (r_borrow),
        .z     (w_z),
        .b_out (w_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= b_in;
                        r_idx    <= '0;
                        r_diff   <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff   <= w_next_diff;
                    r_borrow <= w_bo;
                    r_idx    <= r_idx + IDXW'(1);
                    // Final slice: flags see the completed difference.
                    if (r_idx == LAST) begin
                        r_state <= S_DONE;
                        r_bout  <= w_bo;
                        r_ovf   <= (r_a[WIDTH-1] ^ r_b[WIDTH-1])
                                 & (w_z[SLICE-1] ^ r_a[WIDTH-1]);
                        r_zero  <= (w_next_diff == '0);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign diff     = r_diff;
    assign b_out    = r_bout;
    assign overflow = r_ovf;
    assign zero     = r_zero;
endmodule
